// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the alu_seq sequencer and
//                the combinational alu it drives.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_seq_state_e;

  // ALU select encodings, shared by alu_seq and alu
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational add/sub/and/or unit with zero and negative
//                flags. Results wrap modulo 2^DWIDTH.
//  Revision    : 1.0  initial release
// ============================================================================
module alu
  import alu_seq_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic [1:0]        i_sel,
  input  logic [DWIDTH-1:0] i_op1,
  input  logic [DWIDTH-1:0] i_op2,
  output logic [DWIDTH-1:0] o_res,
  output logic              o_zero,
  output logic              o_neg
);

  logic [DWIDTH-1:0] w_res;

  // Select the operation result; add/sub truncate naturally to DWIDTH
  always_comb begin
    w_res = '0;
    case (i_sel)
      ALU_ADD: w_res = i_op1 + i_op2;
      ALU_SUB: w_res = i_op1 - i_op2;
      ALU_AND: w_res = i_op1 & i_op2;
      ALU_OR:  w_res = i_op1 | i_op2;
      default: w_res = '0;
    endcase
  end

  assign o_res  = w_res;
  assign o_zero = (w_res == '0);
  assign o_neg  = w_res[DWIDTH-1];

endmodule : alu
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Accumulator-based issue unit. Accepts a command, presents
//                registered operands to an external alu, captures the result
//                into the accumulator and returns it on a response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_load_i,
  input  logic [1:0]        cmd_sel_i,
  input  logic [DWIDTH-1:0] cmd_op_i,
  output logic [1:0]        alu_sel_o,
  output logic [DWIDTH-1:0] alu_op1_o,
  output logic [DWIDTH-1:0] alu_op2_o,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic              alu_zero_i,
  input  logic              alu_neg_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic              rsp_zero_o,
  output logic              rsp_neg_o,
  output logic [DWIDTH-1:0] acc_o,
  output logic [CWIDTH-1:0] op_count_o
);

  alu_seq_state_e    r_state;
  alu_seq_state_e    w_next;
  logic              r_load;
  logic [1:0]        r_sel;
  logic [DWIDTH-1:0] r_op1;
  logic [DWIDTH-1:0] r_op2;
  logic [DWIDTH-1:0] r_acc;
  logic [DWIDTH-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_neg;
  logic [CWIDTH-1:0] r_count;
  logic              w_accept;
  logic              w_rsp_done;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs; EXEC always lasts exactly one cycle
  always_comb begin
    w_next      = r_state;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        w_accept    = cmd_valid_i;
        if (cmd_valid_i) w_next = EXEC;
      end
      EXEC: w_next = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        w_rsp_done  = rsp_ready_i;
        if (rsp_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: snapshot operands on accept, capture result in EXEC, count on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load     <= 1'b0;
      r_sel      <= '0;
      r_op1      <= '0;
      r_op2      <= '0;
      r_acc      <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_neg  <= 1'b0;
      r_count    <= '0;
    end else begin
      if (w_accept) begin
        r_load <= cmd_load_i;
        r_sel  <= cmd_sel_i;
        r_op1  <= r_acc;
        r_op2  <= cmd_op_i;
      end
      if (r_state == EXEC) begin
        // Loads bypass the ALU entirely, so flags are derived from the operand
        if (r_load) begin
          r_acc      <= r_op2;
          r_rsp_data <= r_op2;
          r_rsp_zero <= (r_op2 == '0);
          r_rsp_neg  <= r_op2[DWIDTH-1];
        end else begin
          r_acc      <= alu_res_i;
          r_rsp_data <= alu_res_i;
          r_rsp_zero <= alu_zero_i;
          r_rsp_neg  <= alu_neg_i;
        end
      end
      if (w_rsp_done) r_count <= r_count + 1'b1;
    end
  end

  assign alu_sel_o  = r_sel;
  assign alu_op1_o  = r_op1;
  assign alu_op2_o  = r_op2;
  assign rsp_data_o = r_rsp_data;
  assign rsp_zero_o = r_rsp_zero;
  assign rsp_neg_o  = r_rsp_neg;
  assign acc_o      = r_acc;
  assign op_count_o = r_count;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq wired to alu.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic [1:0]    cmd_sel = 2'b00;
  logic [DW-1:0] cmd_op = '0;
  logic [1:0]    alu_sel;
  logic [DW-1:0] alu_op1, alu_op2, alu_res;
  logic          alu_zero, alu_neg;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero, rsp_neg;
  logic [DW-1:0] acc;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_seq #(.DWIDTH(DW), .CWIDTH(CW)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_load_i(cmd_load), .cmd_sel_i(cmd_sel), .cmd_op_i(cmd_op),
    .alu_sel_o(alu_sel), .alu_op1_o(alu_op1), .alu_op2_o(alu_op2),
    .alu_res_i(alu_res), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_zero_o(rsp_zero), .rsp_neg_o(rsp_neg),
    .acc_o(acc), .op_count_o(op_count)
  );

  alu #(.DWIDTH(DW)) u_alu (
    .i_sel(alu_sel), .i_op1(alu_op1), .i_op2(alu_op2),
    .o_res(alu_res), .o_zero(alu_zero), .o_neg(alu_neg)
  );

  typedef struct packed {
    logic          ld;
    logic [1:0]    sel;
    logic [DW-1:0] op;
    logic [DW-1:0] ed;
    logic          ez;
    logic          en;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          z;
    logic          n;
  } rsp_t;

  vec_t          vecs [9];
  rsp_t          sbq [$];
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_acc = '0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present a command, wait (bounded) for acceptance, then verify the operand snapshot
  task automatic issue(input logic ld, input logic [1:0] sel, input logic [DW-1:0] op);
    int n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_sel = sel; cmd_op = op;
    step();
    cmd_valid = 1'b0;
    check("alu_sel", {30'd0, alu_sel}, {30'd0, sel});
    check("alu_op1", {24'd0, alu_op1}, {24'd0, exp_acc});
    check("alu_op2", {24'd0, alu_op2}, {24'd0, op});
    check("busy_not_ready", {31'd0, cmd_ready}, 32'd0);
  endtask

  // Wait for the response (called one cycle after the accept edge), compare against scoreboard
  task automatic collect();
    int   lat = 0;
    rsp_t e;
    check("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
    while (!rsp_valid && lat < 20) begin step(); lat++; end
    check("rsp_latency", lat + 1, 32'd2);
    if (sbq.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check("rsp_data", {24'd0, rsp_data}, {24'd0, e.d});
      check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
      check("rsp_neg",  {31'd0, rsp_neg},  {31'd0, e.n});
      check("acc",      {24'd0, acc},      {24'd0, e.d});
      exp_acc = e.d;
    end
    if (rsp_ready) begin
      step();
      exp_cnt++;
      check("op_count", {16'd0, op_count}, {16'd0, exp_cnt});
      check("valid_drop", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{ld:1'b1, sel:ALU_ADD, op:8'h05, ed:8'h05, ez:1'b0, en:1'b0};
    vecs[1] = '{ld:1'b0, sel:ALU_ADD, op:8'h03, ed:8'h08, ez:1'b0, en:1'b0};
    vecs[2] = '{ld:1'b0, sel:ALU_SUB, op:8'h08, ed:8'h00, ez:1'b1, en:1'b0};
    vecs[3] = '{ld:1'b0, sel:ALU_SUB, op:8'h01, ed:8'hFF, ez:1'b0, en:1'b1};
    vecs[4] = '{ld:1'b1, sel:ALU_ADD, op:8'hFF, ed:8'hFF, ez:1'b0, en:1'b1};
    vecs[5] = '{ld:1'b0, sel:ALU_ADD, op:8'h02, ed:8'h01, ez:1'b0, en:1'b0};
    vecs[6] = '{ld:1'b1, sel:ALU_ADD, op:8'hF0, ed:8'hF0, ez:1'b0, en:1'b1};
    vecs[7] = '{ld:1'b0, sel:ALU_OR,  op:8'h0F, ed:8'hFF, ez:1'b0, en:1'b1};
    vecs[8] = '{ld:1'b0, sel:ALU_AND, op:8'h3C, ed:8'h3C, ez:1'b0, en:1'b0};

    // Reset held for two cycles
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_acc",       {24'd0, acc},       32'd0);
    check("rst_count",     {16'd0, op_count},  32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_alu_sel",   {30'd0, alu_sel},   32'd0);
    check("rst_alu_op1",   {24'd0, alu_op1},   32'd0);
    check("rst_alu_op2",   {24'd0, alu_op2},   32'd0);

    // Table-driven command sequence with the consumer always ready
    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].ld, vecs[i].sel, vecs[i].op);
      sbq.push_back('{d:vecs[i].ed, z:vecs[i].ez, n:vecs[i].en});
      collect();
    end

    // Backpressure: hold the response while a second command waits
    rsp_ready = 1'b0;
    issue(1'b1, ALU_ADD, 8'h55);
    sbq.push_back('{d:8'h55, z:1'b0, n:1'b0});
    collect();
    exp_acc = 8'h55;
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = ALU_ADD; cmd_op = 8'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_data",  {24'd0, rsp_data},  32'h55);
      check("bp_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_op2",   {24'd0, alu_op2},   32'h55);
      check("bp_count", {16'd0, op_count},  {16'd0, exp_cnt});
    end
    rsp_ready = 1'b1;
    step();
    exp_cnt++;
    check("bp_hs_count", {16'd0, op_count},  {16'd0, exp_cnt});
    check("bp_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("bp_hs_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_not_yet",  {24'd0, alu_op2},   32'h55);
    step();
    cmd_valid = 1'b0;
    check("bp_acc_op2", {24'd0, alu_op2}, 32'h01);
    check("bp_acc_op1", {24'd0, alu_op1}, 32'h55);
    sbq.push_back('{d:8'h56, z:1'b0, n:1'b0});
    collect();

    // Reset during EXEC of ADD 0x10: operation dropped
    issue(1'b0, ALU_ADD, 8'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_acc = '0;
    exp_cnt = '0;
    check("mid_rst_acc",   {24'd0, acc},       32'd0);
    check("mid_rst_count", {16'd0, op_count},  32'd0);
    check("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      step();
    end

    // Normal operation resumes after the dropped command
    issue(1'b0, ALU_SUB, 8'h01);
    sbq.push_back('{d:8'hFF, z:1'b0, n:1'b1});
    collect();

    check("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule : tb_alu_seq
`default_nettype wire
